// File: rtl/life_grid_engine.sv
// life_grid_engine
// Cell-grid datapath for the Life game controller. It holds a toroidal ROWS x COLS
// grid, seeds it serially on load_data, computes one generation per step_req (one row
// per cycle into a shadow grid, then a single commit), and dumps the grid serially on
// writeout. It reports the live population, a generation counter and an extinction flag.
//
// Ports
//   clka        in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   restart     in   clear grid, pointers and counters (level, any state)
//   load_data   in   seed_bit valid this cycle (honoured only when idle)
//   seed_bit    in   seed cell value, loaded row-major
//   step_req    in   request one generation
//   writeout    in   request a serial dump of the grid
//   busy        out  engine is computing, committing or dumping
//   gen_done    out  one-cycle pulse: new generation and its statistics are visible
//   out_valid   out  out_bit carries a dumped cell
//   out_bit     out  dumped cell value, cell 0 first
//   out_last    out  marks the final dumped cell
//   lose_sig    out  population became zero at the last commit
//   population  out  live-cell count of the committed grid
//   gen_count   out  generations committed since restart

module life_grid_engine #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int CNTW = 9
) (
  input  logic                             clka,
  input  logic                             rst_n,
  input  logic                             restart,
  input  logic                             load_data,
  input  logic                             seed_bit,
  input  logic                             step_req,
  input  logic                             writeout,
  output logic                             busy,
  output logic                             gen_done,
  output logic                             out_valid,
  output logic                             out_bit,
  output logic                             out_last,
  output logic                             lose_sig,
  output logic [$clog2(ROWS*COLS+1)-1:0]   population,
  output logic [CNTW-1:0]                  gen_count
);

  localparam int CELLS = ROWS * COLS;
  localparam int PW    = $clog2(CELLS + 1);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT, DUMP} state_e;

  state_e                      state_q;
  logic [ROWS-1:0][COLS-1:0]   grid_q;
  logic [ROWS-1:0][COLS-1:0]   shadow_q;
  logic [RW-1:0]               rowPtr_q;
  logic [RW-1:0]               loadRow_q;
  logic [CW-1:0]               loadCol_q;
  logic [RW-1:0]               dumpRow_q;
  logic [CW-1:0]               dumpCol_q;
  logic [PW-1:0]               pop_q;
  logic [CNTW-1:0]             genCount_q;
  logic                        lose_q;
  logic                        donePend_q;
  logic                        genDone_q;
  logic                        outValid_q;
  logic                        outBit_q;
  logic                        outLast_q;

  logic [RW-1:0]               rowUpIdx;
  logic [RW-1:0]               rowDnIdx;
  logic [COLS-1:0]             rowUp;
  logic [COLS-1:0]             rowCur;
  logic [COLS-1:0]             rowDn;
  logic [COLS-1:0]             shadowRow_d;
  logic                        dumpLast;

  function automatic logic [PW-1:0] popCount(input logic [CELLS-1:0] cells);
    logic [PW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < CELLS; i++) cnt = cnt + PW'(cells[i]);
    return cnt;
  endfunction

  // Row neighbours of the row being computed, wrapping top/bottom edges.
  assign rowUpIdx = (rowPtr_q == '0) ? LAST_ROW : rowPtr_q - RW'(1);
  assign rowDnIdx = (rowPtr_q == LAST_ROW) ? '0 : rowPtr_q + RW'(1);
  assign rowUp    = grid_q[rowUpIdx];
  assign rowCur   = grid_q[rowPtr_q];
  assign rowDn    = grid_q[rowDnIdx];

  // One Life rule evaluator per column; left/right neighbours wrap at the side edges.
  for (genvar c = 0; c < COLS; c++) begin : g_cell
    localparam int CL = (c == 0) ? COLS - 1 : c - 1;
    localparam int CR = (c == COLS - 1) ? 0 : c + 1;
    logic [3:0] nbrCnt;
    assign nbrCnt = 4'(rowUp[CL]) + 4'(rowUp[c]) + 4'(rowUp[CR]) +
                    4'(rowCur[CL])                + 4'(rowCur[CR]) +
                    4'(rowDn[CL]) + 4'(rowDn[c]) + 4'(rowDn[CR]);
    assign shadowRow_d[c] = (nbrCnt == 4'd3) || (rowCur[c] && (nbrCnt == 4'd2));
  end

  assign dumpLast = (dumpRow_q == LAST_ROW) && (dumpCol_q == LAST_COL);

  // Control FSM and datapath registers. Restart is treated exactly like reset because
  // both must abandon any in-flight work and return to an empty grid. Population is
  // recounted from the committed grid every cycle, so it trails a load or commit by one
  // cycle, which is also why gen_done is delayed one cycle past the commit.
  always_ff @(posedge clka) begin
    if (!rst_n || restart) begin
      state_q    <= IDLE;
      grid_q     <= '0;
      shadow_q   <= '0;
      rowPtr_q   <= '0;
      loadRow_q  <= '0;
      loadCol_q  <= '0;
      dumpRow_q  <= '0;
      dumpCol_q  <= '0;
      pop_q      <= '0;
      genCount_q <= '0;
      lose_q     <= 1'b0;
      donePend_q <= 1'b0;
      genDone_q  <= 1'b0;
      outValid_q <= 1'b0;
      outBit_q   <= 1'b0;
      outLast_q  <= 1'b0;
    end else begin
      pop_q      <= popCount(grid_q);
      genDone_q  <= donePend_q;
      donePend_q <= 1'b0;
      outValid_q <= 1'b0;
      outBit_q   <= 1'b0;
      outLast_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_data) begin
            grid_q[loadRow_q][loadCol_q] <= seed_bit;
            lose_q <= 1'b0;
            if (loadCol_q == LAST_COL) begin
              loadCol_q <= '0;
              loadRow_q <= (loadRow_q == LAST_ROW) ? '0 : loadRow_q + RW'(1);
            end else begin
              loadCol_q <= loadCol_q + CW'(1);
            end
          end else if (writeout) begin
            state_q   <= DUMP;
            dumpRow_q <= '0;
            dumpCol_q <= '0;
          end else if (step_req) begin
            state_q  <= COMPUTE;
            rowPtr_q <= '0;
          end
        end
        COMPUTE: begin
          shadow_q[rowPtr_q] <= shadowRow_d;
          if (rowPtr_q == LAST_ROW) begin
            state_q <= COMMIT;
          end else begin
            rowPtr_q <= rowPtr_q + RW'(1);
          end
        end
        COMMIT: begin
          grid_q     <= shadow_q;
          genCount_q <= genCount_q + CNTW'(1);
          lose_q     <= (popCount(shadow_q) == '0);
          donePend_q <= 1'b1;
          state_q    <= IDLE;
        end
        DUMP: begin
          outValid_q <= 1'b1;
          outBit_q   <= grid_q[dumpRow_q][dumpCol_q];
          outLast_q  <= dumpLast;
          if (dumpLast) begin
            state_q <= IDLE;
          end else if (dumpCol_q == LAST_COL) begin
            dumpCol_q <= '0;
            dumpRow_q <= dumpRow_q + RW'(1);
          end else begin
            dumpCol_q <= dumpCol_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign gen_done   = genDone_q;
  assign out_valid  = outValid_q;
  assign out_bit    = outBit_q;
  assign out_last   = outLast_q;
  assign lose_sig   = lose_q;
  assign population = pop_q;
  assign gen_count  = genCount_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Testbench for life_grid_engine: directed seed patterns with hand-computed next
// generations, observed through the serial dump port, plus reset/abort/busy cases.

module tb_life_grid_engine;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int CNTW  = 9;
  localparam int CELLS = ROWS * COLS;
  localparam int PW    = $clog2(CELLS + 1);

  localparam logic [63:0] BLINK_H  = 64'h0000_0000_0000_0E00;
  localparam logic [63:0] BLINK_V  = 64'h0000_0000_0004_0404;
  localparam logic [63:0] BLOCK    = 64'h0000_0000_0000_0303;
  localparam logic [63:0] WRAP_IN  = 64'h0000_0000_0080_8080;
  localparam logic [63:0] WRAP_OUT = 64'h0000_0000_0000_C100;
  localparam logic [63:0] SINGLE   = 64'h0000_0000_0800_0000;

  logic            clka = 1'b0;
  logic            rst_n;
  logic            restart;
  logic            load_data;
  logic            seed_bit;
  logic            step_req;
  logic            writeout;
  logic            busy;
  logic            gen_done;
  logic            out_valid;
  logic            out_bit;
  logic            out_last;
  logic            lose_sig;
  logic [PW-1:0]   population;
  logic [CNTW-1:0] gen_count;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clka = ~clka;

  life_grid_engine #(.ROWS(ROWS), .COLS(COLS), .CNTW(CNTW)) dut (
    .clka(clka), .rst_n(rst_n), .restart(restart), .load_data(load_data),
    .seed_bit(seed_bit), .step_req(step_req), .writeout(writeout), .busy(busy),
    .gen_done(gen_done), .out_valid(out_valid), .out_bit(out_bit), .out_last(out_last),
    .lose_sig(lose_sig), .population(population), .gen_count(gen_count)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs (from a negedge) and return at the next negedge,
  // i.e. just after the rising edge that sampled them.
  task automatic applyStimulus(input logic rs, input logic ld, input logic sb,
                               input logic st, input logic wr);
    restart   = rs;
    load_data = ld;
    seed_bit  = sb;
    step_req  = st;
    writeout  = wr;
    @(negedge clka);
  endtask

  task automatic loadPattern(input logic [63:0] pat);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < CELLS; i++) applyStimulus(1'b0, 1'b1, pat[i], 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Returns the number of edges from the step edge to the first gen_done, -1 on timeout.
  task automatic stepGen(output int lat);
    lat = -1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (gen_done) begin
        lat = k;
        break;
      end
    end
  endtask

  // Dump the grid; stepAt selects a cycle (0 = with writeout) to also raise step_req.
  task automatic dumpGrid(input int stepAt, output logic [63:0] g, output int nValid,
                          output int lastIdx, output int lastCnt, output int firstK);
    g = '0; nValid = 0; lastIdx = -1; lastCnt = 0; firstK = -1;
    applyStimulus(1'b0, 1'b0, 1'b0, stepAt == 0, 1'b1);
    for (int k = 1; k <= CELLS + 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, stepAt == k, 1'b0);
      if (out_valid) begin
        if (firstK < 0) firstK = k;
        if (nValid < CELLS) g[nValid] = out_bit;
        if (out_last) begin
          lastIdx = nValid;
          lastCnt++;
        end
        nValid++;
      end
    end
  endtask

  task automatic checkDump(input string tag, input logic [63:0] expGrid, input int stepAt);
    logic [63:0] g;
    int nValid, lastIdx, lastCnt, firstK;
    dumpGrid(stepAt, g, nValid, lastIdx, lastCnt, firstK);
    checkOutput({tag, "_grid"}, g, expGrid);
    checkOutput({tag, "_count"}, 64'(nValid), 64'(CELLS));
    checkOutput({tag, "_lastIdx"}, 64'(lastIdx), 64'(CELLS - 1));
    checkOutput({tag, "_lastCnt"}, 64'(lastCnt), 64'd1);
    checkOutput({tag, "_firstK"}, 64'(firstK), 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int doneSeen;
    int validCnt;
    bit aborted;

    rst_n = 1'b0; restart = 1'b0; load_data = 1'b0; seed_bit = 1'b0;
    step_req = 1'b0; writeout = 1'b0;
    repeat (3) @(negedge clka);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_outValid", 64'(out_valid), 64'd0);
    checkOutput("rst_population", 64'(population), 64'd0);
    checkOutput("rst_genCount", 64'(gen_count), 64'd0);
    checkOutput("rst_lose", 64'(lose_sig), 64'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset during compute");
    loadPattern(BLINK_H);
    checkOutput("midrst_popBefore", 64'(population), 64'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_busyBefore", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clka);
    rst_n = 1'b1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_population", 64'(population), 64'd0);
    checkOutput("midrst_genCount", 64'(gen_count), 64'd0);
    checkOutput("midrst_genDone", 64'(gen_done), 64'd0);
    doneSeen = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (gen_done) doneSeen++;
    end
    checkOutput("midrst_noDone", 64'(doneSeen), 64'd0);
    checkDump("midrst", 64'd0, -1);

    $display("[TB] blinker");
    loadPattern(BLINK_H);
    stepGen(lat);
    checkOutput("blink1_latency", 64'(lat), 64'd10);
    checkOutput("blink1_population", 64'(population), 64'd3);
    checkOutput("blink1_genCount", 64'(gen_count), 64'd1);
    checkOutput("blink1_busy", 64'(busy), 64'd0);
    checkDump("blink1", BLINK_V, -1);
    stepGen(lat);
    checkOutput("blink2_latency", 64'(lat), 64'd10);
    checkOutput("blink2_genCount", 64'(gen_count), 64'd2);
    checkDump("blink2", BLINK_H, -1);

    $display("[TB] block");
    loadPattern(BLOCK);
    stepGen(lat);
    checkOutput("block_latency", 64'(lat), 64'd10);
    checkOutput("block_population", 64'(population), 64'd4);
    checkOutput("block_lose", 64'(lose_sig), 64'd0);
    checkDump("block", BLOCK, -1);

    $display("[TB] toroidal wrap");
    loadPattern(WRAP_IN);
    stepGen(lat);
    checkOutput("wrap_population", 64'(population), 64'd3);
    checkDump("wrap", WRAP_OUT, -1);

    $display("[TB] extinction");
    loadPattern(SINGLE);
    checkOutput("ext_loseBefore", 64'(lose_sig), 64'd0);
    stepGen(lat);
    checkOutput("ext_latency", 64'(lat), 64'd10);
    checkOutput("ext_population", 64'(population), 64'd0);
    checkOutput("ext_lose", 64'(lose_sig), 64'd1);
    checkOutput("ext_genCount", 64'(gen_count), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ext_loseHeld", 64'(lose_sig), 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ext_loseCleared", 64'(lose_sig), 64'd0);

    $display("[TB] requests while busy");
    loadPattern(BLINK_H);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    doneSeen = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (gen_done) doneSeen++;
    end
    checkOutput("busyStep_doneCount", 64'(doneSeen), 64'd1);
    checkOutput("busyStep_genCount", 64'(gen_count), 64'd1);
    checkDump("dumpStep", BLINK_V, 5);
    repeat (15) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("dumpStep_genCount", 64'(gen_count), 64'd1);
    checkDump("bothReq", BLINK_V, 0);
    repeat (15) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("bothReq_genCount", 64'(gen_count), 64'd1);

    $display("[TB] dump abort");
    validCnt = 0;
    aborted  = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= CELLS + 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (out_valid) validCnt++;
      if (validCnt == 20) begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_outValid", 64'(out_valid), 64'd0);
        checkOutput("abort_genCount", 64'(gen_count), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_population", 64'(population), 64'd0);
        aborted = 1'b1;
        break;
      end
    end
    checkOutput("abort_reached", 64'(aborted), 64'd1);
    validCnt = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (out_valid) validCnt++;
    end
    checkOutput("abort_quiet", 64'(validCnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
